axi_read_arbiter: RTL and testbench
===================================

Name: axi_read_arbiter

Overview:
- Arbitrates the shared AXI read-address path between master M0 (instruction fetch) and master M1 (data) across slaves S0–S5 plus the default slave (index 6).
- Grants one master at a time using round-robin priority and decodes ARADDR to a slave index.
- Holds the grant until the final read beat (RLAST) has been handshaked.
- Exports the selected slave and granted master, which the R/ARREADY response routing logic uses to steer returning data.

Parameters:
- ID_W, 4, master-side ARID width
- IDS_W, 8, slave-side ARID width; value is {4'b master tag, ARID}, where M0 tag = 4'h1 and M1 tag = 4'h2
- ADDR_W, 32, address width

Ports:
- ACLK  in  1  clock
- ARESETn  in  1  asynchronous active-low reset
- ARID_M0/ARID_M1  in  ID_W  master read IDs
- ARADDR_M0/ARADDR_M1  in  ADDR_W  master read addresses
- ARLEN_M0/ARLEN_M1  in  4  burst length minus 1
- ARSIZE_M0/ARSIZE_M1  in  3  beat size
- ARBURST_M0/ARBURST_M1  in  2  burst type
- ARVALID_M0/ARVALID_M1  in  1  master address valid
- ARREADY_M0/ARREADY_M1  out  1  master address ready
- ARID_S  out  IDS_W  shared AR ID
- ARADDR_S  out  ADDR_W  shared AR address
- ARLEN_S  out  4  shared AR burst length
- ARSIZE_S  out  3  shared AR beat size
- ARBURST_S  out  2  shared AR burst type
- ARVALID_S  out  7  one-hot ARVALID to S0..S5 and default slave
- ARREADY_S  in  7  per-slave ARREADY
- RVALID  in  1  R channel valid, already muxed from the selected slave
- RREADY  in  1  R channel ready, already muxed from the granted master
- RLAST  in  1  R channel last, already muxed from the selected slave
- r_sel  out  3  selected slave index (0–6)
- r_master  out  1  granted master (0 = M0, 1 = M1)
- r_busy  out  1  high in ADDR or DATA state
- rlast_err  out  1  one-cycle pulse on a burst-length mismatch

Behaviour:
- Reset (asynchronous, ARESETn low):
  - State = IDLE; rr_last = 1, so M0 wins the first tie.
  - r_sel = 0, r_master = 0, r_busy = 0, rlast_err = 0, beat_cnt = 0, len_q = 0.
  - All AR outputs are 0; ARVALID_S = 0; ARREADY_M0/M1 = 0.
- Address decode (combinational on the requesting master's ARADDR):
  - S0: 0x0000_0000–0x0000_3FFF
  - S1: 0x0001_0000–0x0001_FFFF
  - S2: 0x0002_0000–0x0002_FFFF
  - S3: 0x1000_0000–0x1000_03FF
  - S4: 0x1001_0000–0x1001_03FF
  - S5: 0x2000_0000–0x201F_FFFF
  - Any other address: default slave (6).
- IDLE:
  - Only M0 valid: grant M0. Only M1 valid: grant M1.
  - Both valid: grant the master != rr_last.
  - On grant, register r_master, r_sel (decoded), len_q = ARLEN of the granted master, and the AR payload; go to ADDR next cycle.
  - Grant latency is 1 cycle from ARVALID.
  - Both ARREADY_M* stay 0 in IDLE.
- ADDR:
  - ARVALID_S[r_sel] = 1; the payload is driven from registers and stays stable.
  - ARREADY_M[r_master] = ARREADY_S[r_sel] (combinational passthrough); the other master's ARREADY = 0.
  - On ARREADY_S[r_sel] = 1: handshake completes that cycle; go to DATA; rr_last = r_master; beat_cnt = 0.
- DATA:
  - ARVALID_S = 0.
  - Each RVALID & RREADY cycle increments beat_cnt (4-bit).
  - Beat with RLAST = 1: go to IDLE next cycle; r_busy drops.
  - rlast_err pulses (1 cycle) if RLAST arrives with beat_cnt != len_q, or if beat_cnt == len_q without RLAST. On the latter error, stay in DATA until RLAST.
- Arbitration rules:
  - A new grant is evaluated only in IDLE; minimum 1 idle cycle between bursts.
  - A master deasserting ARVALID during ADDR is a master protocol violation; the grant is held regardless.
  - A request arriving in ADDR or DATA waits; no preemption.
- Boundaries:
  - beat_cnt wraps at 16, consistent with the 4-bit ARLEN.
  - ARLEN = 0: a single beat; RLAST must arrive on the first beat.
  - A reset assertion mid-burst returns to IDLE immediately and clears all outputs.

Test Plan:
- Only M0 requests ARADDR 0x0001_0040, ARLEN 0:
  - ADDR next cycle with ARVALID_S = 7'b0000010, r_sel = 1, ARID_S = {4'h1, ARID_M0}.
  - After 1 R beat with RLAST, return to IDLE; rlast_err = 0.
- M0 and M1 request in the same cycle after reset:
  - M0 granted first.
  - M1 granted in the IDLE cycle after M0's RLAST beat.
  - If both request again, M0 is granted next (rr_last = 1).
- M1 read of 0x3000_0000:
  - r_sel = 6 and ARVALID_S = 7'b1000000.
  - ARREADY_M1 follows ARREADY_S[6]; ARREADY_M0 = 0 throughout.
- ARLEN 3 burst to S5 with RVALID gaps and RREADY stalls:
  - beat_cnt counts only handshaked beats.
  - Return to IDLE after the 4th beat; r_busy is high for the whole burst.
- ARLEN 3 burst where RLAST arrives on beat 2: rlast_err pulses once and the FSM returns to IDLE.
- ARESETn driven low during DATA beat 1: all outputs are 0 immediately; the next request after release is granted normally.

Source files
------------

// File: rtl/axi_read_arbiter.sv
// Round-robin AR-channel arbiter for two read masters onto seven slaves.
// Holds the grant from address handshake through the RLAST beat.
module axi_read_arbiter #(
  parameter int ID_W   = 4,
  parameter int IDS_W  = 8,
  parameter int ADDR_W = 32
) (
  input  logic              ACLK,
  input  logic              ARESETn,
  input  logic [ID_W-1:0]   ARID_M0,
  input  logic [ID_W-1:0]   ARID_M1,
  input  logic [ADDR_W-1:0] ARADDR_M0,
  input  logic [ADDR_W-1:0] ARADDR_M1,
  input  logic [3:0]        ARLEN_M0,
  input  logic [3:0]        ARLEN_M1,
  input  logic [2:0]        ARSIZE_M0,
  input  logic [2:0]        ARSIZE_M1,
  input  logic [1:0]        ARBURST_M0,
  input  logic [1:0]        ARBURST_M1,
  input  logic              ARVALID_M0,
  input  logic              ARVALID_M1,
  output logic              ARREADY_M0,
  output logic              ARREADY_M1,
  output logic [IDS_W-1:0]  ARID_S,
  output logic [ADDR_W-1:0] ARADDR_S,
  output logic [3:0]        ARLEN_S,
  output logic [2:0]        ARSIZE_S,
  output logic [1:0]        ARBURST_S,
  output logic [6:0]        ARVALID_S,
  input  logic [6:0]        ARREADY_S,
  input  logic              RVALID,
  input  logic              RREADY,
  input  logic              RLAST,
  output logic [2:0]        r_sel,
  output logic              r_master,
  output logic              r_busy,
  output logic              rlast_err
);

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    DATA
  } state_t;

  typedef struct packed {
    logic [IDS_W-1:0]  id;
    logic [ADDR_W-1:0] addr;
    logic [3:0]        len;
    logic [2:0]        size;
    logic [1:0]        burst;
  } ar_t;

  state_t state, state_nx;
  ar_t    pay_q, pay_in;
  logic   rr_last;
  logic [3:0] beat_cnt;
  logic [3:0] len_q;
  logic   req_any, gnt_m1;
  logic   ar_hs, beat, len_err;

  function automatic logic [2:0] decode(input logic [ADDR_W-1:0] a);
    logic [31:0] x;
    logic [2:0]  s;
    x = 32'(a);
    s = 3'd6;
    unique case (1'b1)
      (x[31:14] == 18'h0):       s = 3'd0;
      (x[31:16] == 16'h0001):    s = 3'd1;
      (x[31:16] == 16'h0002):    s = 3'd2;
      (x[31:10] == 22'h040000):  s = 3'd3;
      (x[31:10] == 22'h040040):  s = 3'd4;
      (x[31:21] == 11'h100):     s = 3'd5;
      default:                   s = 3'd6;
    endcase
    return s;
  endfunction

  assign req_any = ARVALID_M0 | ARVALID_M1;
  // On a tie the master that was not served last wins
  assign gnt_m1  = ARVALID_M1 & (~ARVALID_M0 | ~rr_last);
  assign ar_hs   = (state == ADDR) & ARREADY_S[r_sel];
  assign beat    = (state == DATA) & RVALID & RREADY;
  assign len_err = beat & (RLAST != (beat_cnt == len_q));
  assign len_q   = pay_q.len;

  always_comb begin
    pay_in = '0;
    if (gnt_m1) begin
      pay_in.id    = IDS_W'({4'h2, ARID_M1});
      pay_in.addr  = ARADDR_M1;
      pay_in.len   = ARLEN_M1;
      pay_in.size  = ARSIZE_M1;
      pay_in.burst = ARBURST_M1;
    end else begin
      pay_in.id    = IDS_W'({4'h1, ARID_M0});
      pay_in.addr  = ARADDR_M0;
      pay_in.len   = ARLEN_M0;
      pay_in.size  = ARSIZE_M0;
      pay_in.burst = ARBURST_M0;
    end
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) state <= IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx   = state;
    ARVALID_S  = '0;
    ARREADY_M0 = 1'b0;
    ARREADY_M1 = 1'b0;
    r_busy     = 1'b0;
    unique case (state)
      IDLE: begin
        if (req_any) state_nx = ADDR;
      end
      ADDR: begin
        r_busy     = 1'b1;
        ARVALID_S  = 7'(1) << r_sel;
        ARREADY_M0 = ar_hs & ~r_master;
        ARREADY_M1 = ar_hs & r_master;
        if (ar_hs) state_nx = DATA;
      end
      DATA: begin
        r_busy = 1'b1;
        if (beat && RLAST) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      rr_last   <= 1'b1;
      r_master  <= 1'b0;
      r_sel     <= 3'd0;
      pay_q     <= '0;
      beat_cnt  <= 4'd0;
      rlast_err <= 1'b0;
    end else begin
      rlast_err <= len_err;
      if (state == IDLE && req_any) begin
        r_master <= gnt_m1;
        r_sel    <= decode(gnt_m1 ? ARADDR_M1 : ARADDR_M0);
        pay_q    <= pay_in;
      end
      if (ar_hs) begin
        rr_last  <= r_master;
        beat_cnt <= 4'd0;
      end
      // Wraps at 16 like the 4-bit burst length
      if (beat) beat_cnt <= beat_cnt + 4'd1;
    end
  end

  assign ARID_S    = pay_q.id;
  assign ARADDR_S  = pay_q.addr;
  assign ARLEN_S   = pay_q.len;
  assign ARSIZE_S  = pay_q.size;
  assign ARBURST_S = pay_q.burst;

endmodule

// File: tb/tb_axi_read_arbiter.sv
// Bench for axi_read_arbiter: decode table, directed corner cases,
// and random traffic checked against a transaction-level model.
module tb_axi_read_arbiter;

  logic        ACLK = 1'b0;
  logic        ARESETn;
  logic [3:0]  ARID_M0, ARID_M1;
  logic [31:0] ARADDR_M0, ARADDR_M1;
  logic [3:0]  ARLEN_M0, ARLEN_M1;
  logic [2:0]  ARSIZE_M0, ARSIZE_M1;
  logic [1:0]  ARBURST_M0, ARBURST_M1;
  logic        ARVALID_M0, ARVALID_M1;
  logic        ARREADY_M0, ARREADY_M1;
  logic [7:0]  ARID_S;
  logic [31:0] ARADDR_S;
  logic [3:0]  ARLEN_S;
  logic [2:0]  ARSIZE_S;
  logic [1:0]  ARBURST_S;
  logic [6:0]  ARVALID_S;
  logic [6:0]  ARREADY_S;
  logic        RVALID, RREADY, RLAST;
  logic [2:0]  r_sel;
  logic        r_master, r_busy, rlast_err;

  axi_read_arbiter dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .ARID_M0(ARID_M0), .ARID_M1(ARID_M1),
    .ARADDR_M0(ARADDR_M0), .ARADDR_M1(ARADDR_M1),
    .ARLEN_M0(ARLEN_M0), .ARLEN_M1(ARLEN_M1),
    .ARSIZE_M0(ARSIZE_M0), .ARSIZE_M1(ARSIZE_M1),
    .ARBURST_M0(ARBURST_M0), .ARBURST_M1(ARBURST_M1),
    .ARVALID_M0(ARVALID_M0), .ARVALID_M1(ARVALID_M1),
    .ARREADY_M0(ARREADY_M0), .ARREADY_M1(ARREADY_M1),
    .ARID_S(ARID_S), .ARADDR_S(ARADDR_S), .ARLEN_S(ARLEN_S),
    .ARSIZE_S(ARSIZE_S), .ARBURST_S(ARBURST_S),
    .ARVALID_S(ARVALID_S), .ARREADY_S(ARREADY_S),
    .RVALID(RVALID), .RREADY(RREADY), .RLAST(RLAST),
    .r_sel(r_sel), .r_master(r_master),
    .r_busy(r_busy), .rlast_err(rlast_err)
  );

  always #5 ACLK = ~ACLK;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  string tag = "init";

  logic [63:0] dut_b;
  assign dut_b = {ARID_S, ARADDR_S, ARLEN_S, ARSIZE_S, ARBURST_S,
                  ARVALID_S, ARREADY_M0, ARREADY_M1,
                  r_sel, r_master, r_busy, rlast_err};

  // Slave address windows, inclusive
  int unsigned lo[6] = '{32'h0000_0000, 32'h0001_0000, 32'h0002_0000,
                         32'h1000_0000, 32'h1001_0000, 32'h2000_0000};
  int unsigned hi[6] = '{32'h0000_3FFF, 32'h0001_FFFF, 32'h0002_FFFF,
                         32'h1000_03FF, 32'h1001_03FF, 32'h201F_FFFF};

  // Transaction-level model: phase 0 idle, 1 waiting for AR, 2 in burst
  int   ph, sel, len, beats;
  bit   own, rr, err, hs0, hs1;
  logic [7:0]  mid;
  logic [31:0] maddr;
  logic [3:0]  mlen;
  logic [2:0]  msize;
  logic [1:0]  mburst;

  function automatic int ref_dec(input logic [31:0] a);
    for (int k = 0; k < 6; k++)
      if (a >= lo[k] && a <= hi[k]) return k;
    return 6;
  endfunction

  function automatic logic [63:0] exp_b();
    logic [6:0] arv;
    logic a0, a1;
    arv = '0;
    a0 = 1'b0;
    a1 = 1'b0;
    if (ph == 1) begin
      arv[sel] = 1'b1;
      a0 = !own && ARREADY_S[sel];
      a1 = own && ARREADY_S[sel];
    end
    return {mid, maddr, mlen, msize, mburst, arv, a0, a1,
            3'(sel), own, ph != 0, err};
  endfunction

  task automatic model_reset();
    ph = 0; sel = 0; len = 0; beats = 0;
    own = 0; rr = 1; err = 0;
    mid = '0; maddr = '0; mlen = '0; msize = '0; mburst = '0;
  endtask

  task automatic chk(input string n, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d act=%h exp=%h", n, cyc, act, exp);
    end
  endtask

  task automatic look();
    #1;
    chk(tag, dut_b, exp_b());
  endtask

  task automatic tick();
    bit e;
    e = 0; hs0 = 0; hs1 = 0;
    if (ph == 0) begin
      if (ARVALID_M0 || ARVALID_M1) begin
        own = (ARVALID_M0 && ARVALID_M1) ? !rr : ARVALID_M1;
        if (own) begin
          mid = {4'h2, ARID_M1}; maddr = ARADDR_M1; mlen = ARLEN_M1;
          msize = ARSIZE_M1; mburst = ARBURST_M1;
        end else begin
          mid = {4'h1, ARID_M0}; maddr = ARADDR_M0; mlen = ARLEN_M0;
          msize = ARSIZE_M0; mburst = ARBURST_M0;
        end
        sel = ref_dec(maddr);
        len = int'(mlen);
        ph = 1;
      end
    end else if (ph == 1) begin
      if (ARREADY_S[sel]) begin
        ph = 2; rr = own; beats = 0;
        if (own) hs1 = 1; else hs0 = 1;
      end
    end else if (RVALID && RREADY) begin
      e = RLAST ? (beats != len) : (beats == len);
      beats = (beats + 1) % 16;
      if (RLAST) ph = 0;
    end
    err = e;
    @(negedge ACLK);
    cyc++;
  endtask

  task automatic step();
    look();
    tick();
  endtask

  task automatic drive(input bit m, input logic [31:0] a,
                       input logic [3:0] l, input logic [3:0] id);
    if (!m) begin
      ARADDR_M0 = a; ARLEN_M0 = l; ARID_M0 = id;
      ARSIZE_M0 = 3'd2; ARBURST_M0 = 2'd1; ARVALID_M0 = 1;
    end else begin
      ARADDR_M1 = a; ARLEN_M1 = l; ARID_M1 = id;
      ARSIZE_M1 = 3'd3; ARBURST_M1 = 2'd1; ARVALID_M1 = 1;
    end
  endtask

  task automatic grant_hs(input bit m);
    step();
    ARREADY_S = 7'h7F;
    step();
    if (m) ARVALID_M1 = 0; else ARVALID_M0 = 0;
    ARREADY_S = '0;
  endtask

  task automatic rbeat(input bit last);
    RVALID = 1; RREADY = 1; RLAST = last;
    step();
    RVALID = 0; RREADY = 0; RLAST = 0;
  endtask

  task automatic apply_reset();
    ARESETn = 0;
    #1;
    model_reset();
    chk("reset_zero", dut_b, 64'h0);
    @(negedge ACLK);
    ARESETn = 1;
  endtask

  typedef struct {
    bit          m;
    logic [31:0] addr;
    logic [2:0]  sel;
    logic [6:0]  arv;
  } vec_t;

  vec_t tbl[18];

  initial begin
    tbl[0]  = '{0, 32'h0000_0000, 3'd0, 7'b0000001};
    tbl[1]  = '{1, 32'h0000_3FFF, 3'd0, 7'b0000001};
    tbl[2]  = '{0, 32'h0000_4000, 3'd6, 7'b1000000};
    tbl[3]  = '{1, 32'h0001_0000, 3'd1, 7'b0000010};
    tbl[4]  = '{0, 32'h0001_FFFF, 3'd1, 7'b0000010};
    tbl[5]  = '{1, 32'h0002_0000, 3'd2, 7'b0000100};
    tbl[6]  = '{0, 32'h0002_FFFF, 3'd2, 7'b0000100};
    tbl[7]  = '{1, 32'h0003_0000, 3'd6, 7'b1000000};
    tbl[8]  = '{0, 32'h1000_0000, 3'd3, 7'b0001000};
    tbl[9]  = '{1, 32'h1000_03FF, 3'd3, 7'b0001000};
    tbl[10] = '{0, 32'h1000_0400, 3'd6, 7'b1000000};
    tbl[11] = '{1, 32'h1001_0000, 3'd4, 7'b0010000};
    tbl[12] = '{0, 32'h1001_03FF, 3'd4, 7'b0010000};
    tbl[13] = '{1, 32'h2000_0000, 3'd5, 7'b0100000};
    tbl[14] = '{0, 32'h201F_FFFF, 3'd5, 7'b0100000};
    tbl[15] = '{1, 32'h2020_0000, 3'd6, 7'b1000000};
    tbl[16] = '{0, 32'h3000_0000, 3'd6, 7'b1000000};
    tbl[17] = '{1, 32'hFFFF_FFFF, 3'd6, 7'b1000000};

    ARESETn = 0;
    ARID_M0 = 0; ARID_M1 = 0; ARADDR_M0 = 0; ARADDR_M1 = 0;
    ARLEN_M0 = 0; ARLEN_M1 = 0; ARSIZE_M0 = 0; ARSIZE_M1 = 0;
    ARBURST_M0 = 0; ARBURST_M1 = 0; ARVALID_M0 = 0; ARVALID_M1 = 0;
    ARREADY_S = 0; RVALID = 0; RREADY = 0; RLAST = 0;
    model_reset();
    repeat (2) @(negedge ACLK);
    tag = "reset";
    look();
    chk("reset_zero", dut_b, 64'h0);
    ARESETn = 1;

    tag = "decode";
    for (int i = 0; i < 18; i++) begin
      drive(tbl[i].m, tbl[i].addr, 4'd0, 4'(i));
      step();
      chk("dec_sel", 64'(r_sel), 64'(tbl[i].sel));
      chk("dec_arv", 64'(ARVALID_S), 64'(tbl[i].arv));
      chk("dec_mst", 64'(r_master), 64'(tbl[i].m));
      ARREADY_S = 7'h7F;
      step();
      if (tbl[i].m) ARVALID_M1 = 0; else ARVALID_M0 = 0;
      ARREADY_S = 0;
      rbeat(1);
      step();
    end

    tag = "single_m0";
    apply_reset();
    drive(0, 32'h0001_0040, 4'd0, 4'h5);
    step();
    chk("t1_arv", 64'(ARVALID_S), 64'b0000010);
    chk("t1_sel", 64'(r_sel), 64'd1);
    chk("t1_id", 64'(ARID_S), 64'h15);
    ARREADY_S = 7'b0000010;
    step();
    ARVALID_M0 = 0; ARREADY_S = 0;
    rbeat(1);
    chk("t1_busy", 64'(r_busy), 64'd0);
    chk("t1_err", 64'(rlast_err), 64'd0);
    step();

    tag = "tie";
    apply_reset();
    drive(0, 32'h0000_0100, 4'd0, 4'h3);
    drive(1, 32'h0002_0100, 4'd0, 4'h9);
    step();
    chk("tie_first", 64'(r_master), 64'd0);
    ARREADY_S = 7'h7F;
    step();
    ARVALID_M0 = 0; ARREADY_S = 0;
    rbeat(1);
    step();
    chk("tie_second", 64'(r_master), 64'd1);
    chk("tie_sel2", 64'(r_sel), 64'd2);
    ARREADY_S = 7'h7F;
    step();
    ARVALID_M1 = 0; ARREADY_S = 0;
    rbeat(1);
    drive(0, 32'h0000_0200, 4'd0, 4'h4);
    drive(1, 32'h0002_0200, 4'd0, 4'hA);
    step();
    chk("tie_third", 64'(r_master), 64'd0);
    grant_hs(0);
    ARVALID_M1 = 0;
    rbeat(1);
    step();

    tag = "default_slave";
    drive(1, 32'h3000_0000, 4'd0, 4'h7);
    step();
    chk("dflt_sel", 64'(r_sel), 64'd6);
    chk("dflt_arv", 64'(ARVALID_S), 64'b1000000);
    ARREADY_S = 7'b0111111;
    look();
    chk("dflt_rdy_lo", {ARREADY_M0, ARREADY_M1}, 64'b00);
    tick();
    ARREADY_S = 7'b1000000;
    look();
    chk("dflt_rdy_hi", {ARREADY_M0, ARREADY_M1}, 64'b01);
    tick();
    ARVALID_M1 = 0; ARREADY_S = 0;
    rbeat(1);

    tag = "s5_gaps";
    drive(0, 32'h2000_1000, 4'd3, 4'h2);
    grant_hs(0);
    chk("s5_sel", 64'(r_sel), 64'd5);
    begin
      bit pv[9] = '{1, 0, 1, 0, 1, 1, 1, 0, 1};
      bit pr[9] = '{0, 1, 1, 0, 1, 0, 1, 1, 1};
      int n = 0;
      for (int i = 0; i < 9; i++) begin
        RVALID = pv[i]; RREADY = pr[i]; RLAST = (n == 3);
        chk("s5_busy", 64'(r_busy), 64'd1);
        step();
        if (pv[i] && pr[i]) n++;
      end
      RVALID = 0; RREADY = 0; RLAST = 0;
    end
    chk("s5_done", 64'(r_busy), 64'd0);
    chk("s5_err", 64'(rlast_err), 64'd0);
    step();

    tag = "early_last";
    drive(1, 32'h1000_0010, 4'd3, 4'h1);
    grant_hs(1);
    rbeat(0);
    rbeat(1);
    chk("early_err", 64'(rlast_err), 64'd1);
    chk("early_idle", 64'(r_busy), 64'd0);
    step();
    chk("early_pulse", 64'(rlast_err), 64'd0);

    tag = "reset_mid";
    drive(0, 32'h0000_0040, 4'd2, 4'h6);
    grant_hs(0);
    RVALID = 1; RREADY = 1; RLAST = 0;
    #2;
    ARESETn = 0;
    #1;
    model_reset();
    chk("rmid_zero", dut_b, 64'h0);
    RVALID = 0; RREADY = 0;
    @(negedge ACLK);
    ARESETn = 1;
    drive(1, 32'h1001_0004, 4'd0, 4'hC);
    step();
    chk("rmid_grant", {r_master, ARVALID_S}, {1'b1, 7'b0010000});
    grant_hs(1);
    rbeat(1);

    tag = "random";
    for (int i = 0; i < 600; i++) begin
      for (int m = 0; m < 2; m++) begin
        bit v;
        v = m ? ARVALID_M1 : ARVALID_M0;
        if (!v && $urandom_range(0, 9) < 3) begin
          int k;
          logic [31:0] a;
          k = $urandom_range(0, 6);
          a = (k < 6) ? lo[k] + ($urandom % (hi[k] - lo[k] + 1)) : $urandom;
          drive(m[0], a, 4'($urandom_range(0, 3)), 4'($urandom));
          if (m) begin
            ARSIZE_M1 = 3'($urandom); ARBURST_M1 = 2'($urandom);
          end else begin
            ARSIZE_M0 = 3'($urandom); ARBURST_M0 = 2'($urandom);
          end
        end
      end
      ARREADY_S = 7'($urandom);
      RVALID = $urandom_range(0, 9) < 7;
      RREADY = $urandom_range(0, 9) < 7;
      if (ph == 2 && beats == len) RLAST = $urandom_range(0, 9) != 0;
      else RLAST = $urandom_range(0, 9) == 0;
      step();
      if (hs0) ARVALID_M0 = 0;
      if (hs1) ARVALID_M1 = 0;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
